// File: rtl/rate_update_scheduler.sv
// rate_update_scheduler: arbitrates sw/recovery rate-update requests and commits
// validated half-rates to the rate-tracking datapath, optionally aligned to a
// clock edge. Define RATE_SCHED_ROUND_ROBIN_EN for round-robin arbitration
// (default build: fixed priority, recovery over software).

package clks_alot_p;
   localparam int RATE_COUNTER_WIDTH = 16;
endpackage

module rate_update_scheduler #(
   parameter int W = clks_alot_p::RATE_COUNTER_WIDTH
) (
   input  logic         clk_i,
   input  logic         arst_n_i,
   input  logic         clk_en_i,
   input  logic         sw_req_i,
   input  logic [W-1:0] sw_high_i,
   input  logic [W-1:0] sw_low_i,
   input  logic         rec_req_i,
   input  logic [W-1:0] rec_high_i,
   input  logic [W-1:0] rec_low_i,
   output logic         sw_ack_o,
   output logic         rec_ack_o,
   output logic         err_o,
   input  logic         generation_en_i,
   input  logic         any_valid_edge_i,
   output logic [W-1:0] high_rate_o,
   output logic [W-1:0] low_rate_o,
   output logic         clear_state_o,
   output logic         busy_o,
   output logic         rates_valid_o
);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, COMMIT} state_t;

   state_t         state_q;
   logic [W-1:0]   sh_high_q, sh_low_q, high_q, low_q;
   logic           gnt_rec_q, sw_ack_q, rec_ack_q, err_q, clear_q, valid_q, init_q;
   logic           any_req, pick_rec, pick_bad;
   logic [W-1:0]   pick_high, pick_low;

`ifdef RATE_SCHED_ROUND_ROBIN_EN
   logic           last_rec_q;
   assign pick_rec = rec_req_i & (~sw_req_i | ~last_rec_q);
`else
   assign pick_rec = rec_req_i;
`endif

   assign any_req   = rec_req_i | sw_req_i;
   assign pick_high = pick_rec ? rec_high_i : sw_high_i;
   assign pick_low  = pick_rec ? rec_low_i  : sw_low_i;
   assign pick_bad  = (pick_high == '0) || (pick_low == '0);

   // Scheduler FSM: grant in IDLE, optional edge wait, then one-cycle commit
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q   <= IDLE;
         sh_high_q <= '0;
         sh_low_q  <= '0;
         high_q    <= '0;
         low_q     <= '0;
         gnt_rec_q <= 1'b0;
         sw_ack_q  <= 1'b0;
         rec_ack_q <= 1'b0;
         err_q     <= 1'b0;
         clear_q   <= 1'b0;
         valid_q   <= 1'b0;
         init_q    <= 1'b1;
`ifdef RATE_SCHED_ROUND_ROBIN_EN
         last_rec_q <= 1'b0;
`endif
      end else if (clk_en_i) begin
         sw_ack_q  <= 1'b0;
         rec_ack_q <= 1'b0;
         err_q     <= 1'b0;
         clear_q   <= init_q;
         init_q    <= 1'b0;
         case (state_q)
            IDLE: if (any_req) begin
               gnt_rec_q <= pick_rec;
               sh_high_q <= pick_high;
               sh_low_q  <= pick_low;
`ifdef RATE_SCHED_ROUND_ROBIN_EN
               last_rec_q <= pick_rec;
`endif
               if (pick_bad) begin
                  err_q     <= 1'b1;
                  rec_ack_q <= pick_rec;
                  sw_ack_q  <= ~pick_rec;
               end else begin
                  state_q <= generation_en_i ? WAIT_EDGE : COMMIT;
               end
            end
            WAIT_EDGE: if (any_valid_edge_i || !generation_en_i) state_q <= COMMIT;
            COMMIT: begin
               high_q    <= sh_high_q;
               low_q     <= sh_low_q;
               valid_q   <= 1'b1;
               rec_ack_q <= gnt_rec_q;
               sw_ack_q  <= ~gnt_rec_q;
               clear_q   <= init_q | ~generation_en_i | ~valid_q;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sw_ack_o      = sw_ack_q;
   assign rec_ack_o     = rec_ack_q;
   assign err_o         = err_q;
   assign high_rate_o   = high_q;
   assign low_rate_o    = low_q;
   assign clear_state_o = clear_q;
   assign busy_o        = (state_q != IDLE);
   assign rates_valid_o = valid_q;

endmodule

// File: tb/tb_rate_update_scheduler.sv
// tb_rate_update_scheduler: directed checks of the rate update scheduler
module tb_rate_update_scheduler;
   localparam int W = 16;

   logic         clk_i = 1'b0;
   logic         arst_n_i = 1'b0;
   logic         clk_en_i = 1'b1;
   logic         sw_req_i = 1'b0, rec_req_i = 1'b0;
   logic [W-1:0] sw_high_i = '0, sw_low_i = '0, rec_high_i = '0, rec_low_i = '0;
   logic         sw_ack_o, rec_ack_o, err_o;
   logic         generation_en_i = 1'b0, any_valid_edge_i = 1'b0;
   logic [W-1:0] high_rate_o, low_rate_o;
   logic         clear_state_o, busy_o, rates_valid_o;
   int           errors = 0, checks = 0;

   rate_update_scheduler #(.W(W)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .clk_en_i(clk_en_i),
      .sw_req_i(sw_req_i), .sw_high_i(sw_high_i), .sw_low_i(sw_low_i),
      .rec_req_i(rec_req_i), .rec_high_i(rec_high_i), .rec_low_i(rec_low_i),
      .sw_ack_o(sw_ack_o), .rec_ack_o(rec_ack_o), .err_o(err_o),
      .generation_en_i(generation_en_i), .any_valid_edge_i(any_valid_edge_i),
      .high_rate_o(high_rate_o), .low_rate_o(low_rate_o),
      .clear_state_o(clear_state_o), .busy_o(busy_o), .rates_valid_o(rates_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic exp_rec;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_clear", clear_state_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_high", high_rate_o, 0);
      chk("rst_valid", rates_valid_o, 0);
      arst_n_i = 1'b1;
      step();
      chk("init_clear", clear_state_o, 1);
      step();
      chk("init_clear_off", clear_state_o, 0);
      chk("init_low", low_rate_o, 0);
      // software update with generation disabled
      sw_req_i = 1'b1; sw_high_i = 5; sw_low_i = 3;
      step();
      chk("sw_busy", busy_o, 1);
      chk("sw_ack_early", sw_ack_o, 0);
      step();
      chk("sw_ack", sw_ack_o, 1);
      chk("sw_high", high_rate_o, 5);
      chk("sw_low", low_rate_o, 3);
      chk("sw_clear", clear_state_o, 1);
      chk("sw_valid", rates_valid_o, 1);
      chk("sw_idle", busy_o, 0);
      sw_req_i = 1'b0;
      step();
      chk("sw_ack_pulse", sw_ack_o, 0);
      chk("sw_clear_pulse", clear_state_o, 0);
      // recovery update aligned to an edge
      generation_en_i = 1'b1;
      rec_req_i = 1'b1; rec_high_i = 8; rec_low_i = 8;
      step();
      chk("rec_wait_busy", busy_o, 1);
      step();
      chk("rec_wait_ack", rec_ack_o, 0);
      chk("rec_wait_high", high_rate_o, 5);
      any_valid_edge_i = 1'b1;
      step();
      any_valid_edge_i = 1'b0;
      chk("rec_edge_ack", rec_ack_o, 0);
      chk("rec_edge_low", low_rate_o, 3);
      step();
      chk("rec_ack", rec_ack_o, 1);
      chk("rec_high", high_rate_o, 8);
      chk("rec_low", low_rate_o, 8);
      chk("rec_no_clear", clear_state_o, 0);
      rec_req_i = 1'b0;
      // zero low rate is rejected
      sw_req_i = 1'b1; sw_high_i = 4; sw_low_i = 0;
      step();
      chk("bad_err", err_o, 1);
      chk("bad_ack", sw_ack_o, 1);
      chk("bad_high", high_rate_o, 8);
      chk("bad_low", low_rate_o, 8);
      chk("bad_idle", busy_o, 0);
      sw_req_i = 1'b0;
      step();
      chk("bad_err_pulse", err_o, 0);
      // both requesters held for four grants
      generation_en_i = 1'b0;
      sw_req_i = 1'b1; sw_high_i = 1; sw_low_i = 2;
      rec_req_i = 1'b1; rec_high_i = 3; rec_low_i = 4;
      for (int i = 0; i < 4; i++) begin
`ifdef RATE_SCHED_ROUND_ROBIN_EN
         exp_rec = (i % 2 == 0);
`else
         exp_rec = 1'b1;
`endif
         step();
         step();
         chk($sformatf("arb%0d_rec", i), rec_ack_o, exp_rec);
         chk($sformatf("arb%0d_sw", i), sw_ack_o, !exp_rec);
         chk($sformatf("arb%0d_high", i), high_rate_o, exp_rec ? 3 : 1);
      end
      sw_req_i = 1'b0; rec_req_i = 1'b0;
      step();
      // clock enable low freezes the scheduler
      clk_en_i = 1'b0;
      sw_req_i = 1'b1; sw_high_i = 9; sw_low_i = 9;
      step();
      step();
      chk("cen_busy", busy_o, 0);
      clk_en_i = 1'b1;
      step();
      chk("cen_go", busy_o, 1);
      step();
      chk("cen_ack", sw_ack_o, 1);
      chk("cen_high", high_rate_o, 9);
      sw_req_i = 1'b0;
      step();
      // reset during edge wait abandons the request
      generation_en_i = 1'b1;
      sw_req_i = 1'b1; sw_high_i = 6; sw_low_i = 7;
      step();
      step();
      chk("mid_busy", busy_o, 1);
      arst_n_i = 1'b0;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_high", high_rate_o, 0);
      chk("mid_rst_low", low_rate_o, 0);
      chk("mid_rst_valid", rates_valid_o, 0);
      chk("mid_rst_ack", sw_ack_o, 0);
      chk("mid_rst_clear", clear_state_o, 0);
      sw_req_i = 1'b0;
      arst_n_i = 1'b1;
      step();
      chk("mid_clear", clear_state_o, 1);
      chk("mid_no_ack", sw_ack_o, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
